// File: rtl/ex_multicycle_ctrl.sv
// EX-stage multi-cycle sequencer: 2-cycle MADD/MSUB accumulate and DIV/DIVU divider handshake.
// Sole source of the EX stall request; cnt_o is the accumulate phase fed back through EX/MEM.
module ex_multicycle_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 40,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] aluop_i,
  input  logic       div_zero_i,
  input  logic       div_ready_i,
  input  logic       hold_i,
  input  logic       flush_i,
  output logic [1:0] cnt_o,
  output logic       stallreq_o,
  output logic       div_start_o,
  output logic       div_annul_o,
  output logic       div_err_o
);

  localparam int unsigned ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'b1010_1011;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAC1     = 2'd1,
    DIV_WAIT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               div_err_q, div_err_d;
  logic               is_mac, is_div, timeout;

  assign is_mac  = (aluop_i == EXE_MADD_OP)  || (aluop_i == EXE_MADDU_OP) ||
                   (aluop_i == EXE_MSUB_OP)  || (aluop_i == EXE_MSUBU_OP);
  assign is_div  = (aluop_i == EXE_DIV_OP)   || (aluop_i == EXE_DIVU_OP);
  assign timeout = (wait_cnt_q == CNT_W'(DIV_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      div_err_q  <= div_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    div_err_d   = div_err_q;
    cnt_o       = 2'b00;
    stallreq_o  = 1'b0;
    div_start_o = 1'b0;
    div_annul_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mac) begin
          stallreq_o = 1'b1;
          state_d    = MAC1;
        end else if (is_div && !div_zero_i) begin
          stallreq_o = 1'b1;
          state_d    = DIV_WAIT;
          wait_cnt_d = '0;
        end
      end
      MAC1: begin
        cnt_o   = 2'b01;
        state_d = IDLE;
      end
      DIV_WAIT: begin
        div_start_o = 1'b1;
        stallreq_o  = !div_ready_i;
        if (div_ready_i) begin
          state_d = IDLE;
        end else if (timeout) begin
          div_annul_o = 1'b1;
          stallreq_o  = 1'b0;
          div_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A held stage freezes everything; the abort pulse is deferred until the hold lifts.
    if (hold_i) begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      div_err_d   = div_err_q;
      div_annul_o = 1'b0;
    end

    if (flush_i) begin
      state_d     = IDLE;
      wait_cnt_d  = '0;
      div_err_d   = div_err_q;
      stallreq_o  = 1'b0;
      div_annul_o = (state_q == DIV_WAIT);
    end
  end

  assign div_err_o = div_err_q;

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// Directed self-checking bench for ex_multicycle_ctrl covering MAC, divide, timeout, flush, hold and reset.
module tb_ex_multicycle_ctrl;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aluop;
  logic       div_zero, div_ready, hold, flush;
  logic [1:0] cnt;
  logic       stallreq, div_start, div_annul, div_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ex_multicycle_ctrl #(.DIV_TIMEOUT(40), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .div_zero_i  (div_zero),
    .div_ready_i (div_ready),
    .hold_i      (hold),
    .flush_i     (flush),
    .cnt_o       (cnt),
    .stallreq_o  (stallreq),
    .div_start_o (div_start),
    .div_annul_o (div_annul),
    .div_err_o   (div_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check all combinational outputs for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [1:0] e_cnt, input logic e_stall,
                     input logic e_start, input logic e_annul);
    #1;
    check({tag, ".cnt"},    8'(cnt),       8'(e_cnt));
    check({tag, ".stall"},  8'(stallreq),  8'(e_stall));
    check({tag, ".start"},  8'(div_start), 8'(e_start));
    check({tag, ".annul"},  8'(div_annul), 8'(e_annul));
    tick();
  endtask

  initial begin
    rst = 1'b0; aluop = OP_NOP; div_zero = 1'b0; div_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check("rst.err", 8'(div_err), 8'd0);
    cyc("rst", 2'b00, 1'b0, 1'b0, 1'b0);

    // MADD: one stall cycle, then phase 01, then idle
    aluop = OP_MADD;
    cyc("mac.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("mac.c1", 2'b01, 1'b0, 1'b0, 1'b0);
    aluop = OP_NOP;
    cyc("mac.c2", 2'b00, 1'b0, 1'b0, 1'b0);

    // DIV completing on the 34th wait cycle
    aluop = OP_DIV;
    cyc("div.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 33; i++) cyc($sformatf("div.w%0d", i), 2'b00, 1'b1, 1'b1, 1'b0);
    div_ready = 1'b1;
    cyc("div.w34", 2'b00, 1'b0, 1'b1, 1'b0);
    div_ready = 1'b0; aluop = OP_NOP;
    check("div.err", 8'(div_err), 8'd0);
    cyc("div.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // DIVU by zero never leaves IDLE
    aluop = OP_DIVU; div_zero = 1'b1;
    cyc("dz.c0", 2'b00, 1'b0, 1'b0, 1'b0);
    cyc("dz.c1", 2'b00, 1'b0, 1'b0, 1'b0);
    aluop = OP_NOP; div_zero = 1'b0;
    cyc("dz.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // DIV timeout on the 40th wait cycle
    aluop = OP_DIV;
    cyc("to.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 39; i++) cyc($sformatf("to.w%0d", i), 2'b00, 1'b1, 1'b1, 1'b0);
    check("to.err_pre", 8'(div_err), 8'd0);
    cyc("to.w40", 2'b00, 1'b0, 1'b1, 1'b1);
    aluop = OP_NOP;
    check("to.err_set", 8'(div_err), 8'd1);
    cyc("to.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    check("to.err_sticky", 8'(div_err), 8'd1);

    // Flush with ready on the 5th wait cycle, then MSUB back-to-back
    aluop = OP_DIV;
    cyc("fl.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) cyc($sformatf("fl.w%0d", i), 2'b00, 1'b1, 1'b1, 1'b0);
    flush = 1'b1; div_ready = 1'b1;
    cyc("fl.w5", 2'b00, 1'b0, 1'b1, 1'b1);
    flush = 1'b0; div_ready = 1'b0; aluop = OP_MSUB;
    cyc("fl.msub0", 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("fl.msub1", 2'b01, 1'b0, 1'b0, 1'b0);
    aluop = OP_NOP;
    check("fl.err_kept", 8'(div_err), 8'd1);
    cyc("fl.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Hold in MAC1 for 3 cycles, then reset mid-divide
    aluop = OP_MADD;
    cyc("hd.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 1; i <= 3; i++) cyc($sformatf("hd.h%0d", i), 2'b01, 1'b0, 1'b0, 1'b0);
    hold = 1'b0;
    cyc("hd.rel", 2'b01, 1'b0, 1'b0, 1'b0);
    aluop = OP_NOP;
    cyc("hd.idle", 2'b00, 1'b0, 1'b0, 1'b0);
    aluop = OP_DIV;
    cyc("rs.c0", 2'b00, 1'b1, 1'b0, 1'b0);
    cyc("rs.w1", 2'b00, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc("rs.w2", 2'b00, 1'b1, 1'b1, 1'b0);
    rst = 1'b1; aluop = OP_NOP;
    check("rs.err", 8'(div_err), 8'd0);
    cyc("rs.idle", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
